// File: rtl/dll_lock_ctrl.sv
// Lock supervisor and reset sequencer for the board clock manager.
// Optional RUN loss filter: define DLL_LOCK_CTRL_LOSS_FILTER_EN.
module dll_lock_ctrl #(
  parameter int unsigned RST_CYCLES    = 16,
  parameter int unsigned LOCK_TIMEOUT  = 1048576,
  parameter int unsigned STABLE_CYCLES = 1024,
  parameter int unsigned MAX_RETRY     = 7
) (
  input  logic       clkin,
  input  logic       rst,
  input  logic       locked,
  input  logic       force_relock,
  output logic       dll_rst,
  output logic       sys_rst,
  output logic       ready,
  output logic       fault,
  output logic [2:0] state,
  output logic [7:0] relock_cnt
);

  typedef enum logic [2:0] {
    ST_RESET     = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAULT     = 3'd4
  } state_e;

  localparam logic [23:0] RST_LAST     = 24'(RST_CYCLES - 1);
  localparam logic [23:0] TIMEOUT_LAST = 24'(LOCK_TIMEOUT - 1);
  localparam logic [23:0] STABLE_LAST  = 24'(STABLE_CYCLES - 1);
  localparam logic [3:0]  RETRY_LIM    = 4'(MAX_RETRY);

  state_e      state_q, state_d;
  logic [1:0]  sync_q, sync_d;
  logic [23:0] timer_q, timer_d;
  logic [3:0]  retry_cnt_q, retry_cnt_d;
  logic [7:0]  relock_cnt_q, relock_cnt_d;
  logic        dll_rst_q, dll_rst_d;
  logic        sys_rst_q, sys_rst_d;
  logic        ready_q, ready_d;
  logic        fault_q, fault_d;
  logic        locked_s;
  logic        loss;
  logic        fail;
  logic [3:0]  retry_inc;

  assign sync_d    = {sync_q[0], locked};
  assign locked_s  = sync_q[1];
  assign retry_inc = retry_cnt_q + 4'd1;

`ifdef DLL_LOCK_CTRL_LOSS_FILTER_EN
  logic [1:0] loss_cnt_q, loss_cnt_d;

  // Counts consecutive unlocked RUN cycles; the fourth one is the loss.
  always_comb begin
    loss_cnt_d = (locked_s || state_q != ST_RUN) ? 2'd0 : loss_cnt_q + 2'd1;
    loss       = !locked_s && (loss_cnt_q == 2'd3);
  end
`else
  assign loss = !locked_s;
`endif

  always_comb begin
    state_d      = state_q;
    retry_cnt_d  = retry_cnt_q;
    relock_cnt_d = relock_cnt_q;
    fail         = 1'b0;
    case (state_q)
      ST_RESET:
        if (timer_q == RST_LAST) state_d = ST_WAIT_LOCK;
      ST_WAIT_LOCK:
        if (locked_s) state_d = ST_STABLE;
        else if (timer_q == TIMEOUT_LAST) fail = 1'b1;
      ST_STABLE:
        if (!locked_s) fail = 1'b1;
        else if (timer_q == STABLE_LAST) begin
          state_d     = ST_RUN;
          retry_cnt_d = 4'd0;
        end
      ST_RUN:
        if (loss) begin
          state_d = ST_RESET;
          if (relock_cnt_q != 8'hff) relock_cnt_d = relock_cnt_q + 8'd1;
        end
      ST_FAULT: state_d = ST_FAULT;
      default:  state_d = ST_RESET;
    endcase

    if (fail) begin
      retry_cnt_d = retry_inc;
      state_d     = (RETRY_LIM != 4'd0 && retry_inc == RETRY_LIM) ? ST_FAULT : ST_RESET;
    end

    // A relock request overrides whatever transition was pending, including a loss.
    if (force_relock) begin
      state_d      = ST_RESET;
      retry_cnt_d  = 4'd0;
      relock_cnt_d = relock_cnt_q;
    end

    timer_d   = (force_relock || state_d != state_q) ? 24'd0 : timer_q + 24'd1;
    dll_rst_d = (state_d == ST_RESET);
    sys_rst_d = (state_d != ST_RUN);
    ready_d   = (state_d == ST_RUN);
    fault_d   = (state_d == ST_FAULT);
  end

  always_ff @(posedge clkin or posedge rst) begin
    if (rst) begin
      state_q      <= ST_RESET;
      sync_q       <= 2'b00;
      timer_q      <= 24'd0;
      retry_cnt_q  <= 4'd0;
      relock_cnt_q <= 8'd0;
      dll_rst_q    <= 1'b1;
      sys_rst_q    <= 1'b1;
      ready_q      <= 1'b0;
      fault_q      <= 1'b0;
`ifdef DLL_LOCK_CTRL_LOSS_FILTER_EN
      loss_cnt_q   <= 2'd0;
`endif
    end else begin
      state_q      <= state_d;
      sync_q       <= sync_d;
      timer_q      <= timer_d;
      retry_cnt_q  <= retry_cnt_d;
      relock_cnt_q <= relock_cnt_d;
      dll_rst_q    <= dll_rst_d;
      sys_rst_q    <= sys_rst_d;
      ready_q      <= ready_d;
      fault_q      <= fault_d;
`ifdef DLL_LOCK_CTRL_LOSS_FILTER_EN
      loss_cnt_q   <= loss_cnt_d;
`endif
    end
  end

  assign state      = state_q;
  assign dll_rst    = dll_rst_q;
  assign sys_rst    = sys_rst_q;
  assign ready      = ready_q;
  assign fault      = fault_q;
  assign relock_cnt = relock_cnt_q;

endmodule
